rr_encoder8_3: RTL
==================

Name: rr_encoder8_3

Overview:
8-to-3 arbitrating encoder that performs the inverse of the 3:8 one-hot decode. It takes up to eight request lines, selects one, and presents its 3-bit binary index with a valid/ack handshake. Selection is round-robin or fixed-priority, set by parameter. It sits in front of shared resources in the datapath (register write ports, memory-request muxing) where several one-hot sources must be collapsed to a binary select.

Parameters:
RR_EN, 1, 1 = round-robin priority rotating past the last granted index; 0 = fixed priority, lowest index wins.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  8  request vector; bit i = requester i; multi-hot allowed
ack  input  1  consumer accepts the current grant; sampled only while valid=1
idx  output 3  binary index of the granted requester; registered
valid  output 1  idx/grant hold a live grant; registered
grant  output 8  one-hot decode of idx while valid=1, else 8'h00; registered
err  output 1  one-cycle pulse on a protocol violation; registered

Behaviour:
- Clocking/reset: one clock domain. Reset is synchronous and active-high. rst=1 at an edge gives idx=3'b000, valid=0, grant=8'h00, err=0, ptr=3'b000, state=IDLE. rst overrides all other inputs, including a grant in progress; no ack is implied.
- Internal state: 2-state FSM {IDLE, GRANT}; 3-bit priority pointer ptr.
- Selection function sel(req, ptr):
  - RR_EN=1: first set bit scanning ptr, ptr+1, ..., wrapping 7 to 0, ending at ptr-1 (mod 8).
  - RR_EN=0: ptr is ignored and the scan always starts at 0.
- IDLE:
  - If req==8'h00: stay in IDLE; valid=0, grant=0.
  - Else at the next edge: idx<=sel(req,ptr), grant<=1<<sel, valid<=1, state<=GRANT.
  - Latency is one cycle from req sampled to valid=1.
- GRANT: idx, grant and valid are held stable until the grant closes. Evaluate in this priority order:
  1. ack=1: next edge valid<=0, grant<=0, state<=IDLE.
     - If RR_EN=1, ptr<=idx+1 mod 8 (7 wraps to 0).
     - idx keeps its last value; it is don't-care while valid=0.
     - This is accepted even if req[idx] dropped the same cycle.
  2. ack=0 and req[idx]=0 (requester withdrew before ack): next edge err<=1 for exactly one cycle, valid<=0, grant<=0, state<=IDLE. ptr is unchanged.
  3. Otherwise: hold. Changes on other req bits are ignored until the grant closes.
- Throughput: at least one valid=0 cycle between consecutive grants, so at most one grant every 2 cycles.
- ack while valid=0 is ignored; no error and no state change.
- err is 0 on every cycle other than the violation pulse.
- Invariant: grant == (valid ? 8'h01<<idx : 8'h00) on every cycle.

Test Plan:
1. Reset with req=8'hFF, rst=1 for 2 cycles -> idx=0, valid=0, grant=8'h00, err=0. Release rst -> next cycle valid=1, idx=3'd0, grant=8'h01.
2. RR_EN=1, req=8'hFF held, ack=1 whenever valid -> idx sequence 0,1,2,...,7,0. Each grant is followed by exactly one valid=0 cycle; the 7-to-0 wrap is checked.
3. RR_EN=1, ptr=5 (after a grant of 4), req=8'b0000_1001 -> idx=3'd0, grant=8'h01. After ack -> idx=3'd3. This checks wrap-around search and skipping of idle bits.
4. RR_EN=0, req=8'b1010_0000 then 8'b1010_0001 over repeated acks -> idx=5 every time for the first vector, idx=0 every time for the second; no rotation.
5. Grant idx=2 with ack=0. Toggle req[6] -> outputs stable. Then drop req[2] -> next cycle err=1 for one cycle, valid=0, and ptr unchanged (next grant starts search at the old ptr).
6. rst=1 asserted while valid=1 with idx=6 -> next edge valid=0, grant=0, ptr=0. Then req=8'hC0 -> idx=6. Also: ack pulsed while valid=0 -> no change, err=0.

Source files
------------

// File: rtl/rr_encoder8_3_if.sv
// ---------------------------------------------------------------------------
// rr_encoder8_3_if
// Request/grant bundle between a set of one-hot requesters and the
// rr_encoder8_3 arbitrating encoder.
//   req   [7:0] : request vector, bit i = requester i (multi-hot allowed)
//   ack         : consumer accepts the current grant
//   idx   [2:0] : binary index of the granted requester
//   valid       : idx/grant hold a live grant
//   grant [7:0] : one-hot decode of idx while valid, else zero
//   err         : one-cycle pulse when a requester withdraws before ack
// master = requester/consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface rr_encoder8_3_if;
   logic [7:0] req;
   logic       ack;
   logic [2:0] idx;
   logic       valid;
   logic [7:0] grant;
   logic       err;

   modport master (
      output req,
      output ack,
      input  idx,
      input  valid,
      input  grant,
      input  err
   );

   modport slave (
      input  req,
      input  ack,
      output idx,
      output valid,
      output grant,
      output err
   );
endinterface

// File: rtl/rr_encoder8_3.sv
// ---------------------------------------------------------------------------
// rr_encoder8_3
// 8-to-3 arbitrating encoder. Picks one of up to eight requesters, presents
// its binary index with a valid/ack handshake and holds it until the grant is
// accepted (ack) or the requester withdraws (err pulse).
// Parameters:
//   RR_EN : 1 = round-robin, search starts just past the last accepted index
//           0 = fixed priority, lowest index wins
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_encoder8_3_if.slave (req, ack in; idx, valid, grant, err out,
//          all outputs registered)
// ---------------------------------------------------------------------------
module rr_encoder8_3 #(
   parameter bit RR_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   rr_encoder8_3_if.slave bus
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0] state_r;
   logic [2:0] ptr_r;
   logic [2:0] idx_r;
   logic       valid_r;
   logic [7:0] grant_r;
   logic       err_r;

   logic [0:0] state_s;
   logic [2:0] ptr_s;
   logic [2:0] idx_s;
   logic       valid_s;
   logic [7:0] grant_s;
   logic       err_s;
   logic [2:0] start_s;
   logic [2:0] sel_s;

   // First set bit of r scanning start, start+1, ... with 3-bit wrap.
   function automatic logic [2:0] sel_fn(input logic [7:0] r, input logic [2:0] start);
      logic [2:0] result;
      logic [2:0] pos;
      logic       found;
      result = 3'd0;
      found  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pos    = start + 3'(i);
         result = (!found && r[pos]) ? pos : result;
         found  = found | r[pos];
      end
      return result;
   endfunction

   // Search origin: rotating pointer in round-robin mode, index 0 otherwise.
   always_comb begin
      if (RR_EN) begin
         start_s = ptr_r;
      end else begin
         start_s = 3'd0;
      end
      sel_s = sel_fn(bus.req, start_s);
   end

   // Next-state logic for the IDLE/GRANT handshake.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      idx_s   = idx_r;
      valid_s = valid_r;
      grant_s = grant_r;
      err_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.req != 8'h00) begin
               idx_s   = sel_s;
               grant_s = 8'h01 << sel_s;
               valid_s = 1'b1;
               state_s = ST_GRANT;
            end else begin
               valid_s = 1'b0;
               grant_s = 8'h00;
            end
         end
         ST_GRANT: begin
            // ack wins even if the requester dropped in the same cycle.
            if (bus.ack) begin
               valid_s = 1'b0;
               grant_s = 8'h00;
               state_s = ST_IDLE;
               if (RR_EN) begin
                  ptr_s = idx_r + 3'd1;
               end else begin
                  ptr_s = ptr_r;
               end
            end else if (!bus.req[idx_r]) begin
               // Withdrawal without ack: drop the grant, keep the pointer.
               err_s   = 1'b1;
               valid_s = 1'b0;
               grant_s = 8'h00;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GRANT;
            end
         end
         default: begin
            valid_s = 1'b0;
            grant_s = 8'h00;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         ptr_r   <= 3'd0;
         idx_r   <= 3'd0;
         valid_r <= 1'b0;
         grant_r <= 8'h00;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         idx_r   <= idx_s;
         valid_r <= valid_s;
         grant_r <= grant_s;
         err_r   <= err_s;
      end
   end

   assign bus.idx   = idx_r;
   assign bus.valid = valid_r;
   assign bus.grant = grant_r;
   assign bus.err   = err_r;

endmodule
